// File: rtl/led_pio_pkg.sv
// led_pio_pkg: register addresses and STATUS bit positions for the LED PIO blinker.
package led_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SET      = 3'd1;
  localparam logic [2:0] ADDR_CLEAR    = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd4;
  localparam logic [2:0] ADDR_PERIOD   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;
  localparam int STATUS_PHASE = 0;
  localparam int STATUS_EN    = 1;
endpackage

// File: rtl/led_blink_timer.sv
// led_blink_timer: down-counter that flips phase every period+1 cycles; period 0 disables.
module led_blink_timer #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  load,
  output logic                  phase
);
  logic [PRESCALE_W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b0;
    end else if (load || period == '0) begin
      count <= period;
      phase <= 1'b0;
    end else if (count == '0) begin
      count <= period;
      phase <= ~phase;
    end else begin
      count <= count - PRESCALE_W'(1);
    end
endmodule

// File: rtl/led_pio_blink.sv
// led_pio_blink: memory-mapped LED PIO with set/clear/toggle and masked hardware blink.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data, mask, wd;
  logic [PRESCALE_W-1:0] period, pw;
  logic phase, we, load, unused;
  logic [31:0] status;
  assign we = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign pw = writedata[PRESCALE_W-1:0];
  assign load = we && address == ADDR_PERIOD;
  assign unused = ^writedata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data   <= '0;
      mask   <= '0;
      period <= '0;
    end else if (we) begin
      case (address)
        ADDR_DATA:     data <= wd;
        ADDR_SET:      data <= data | wd;
        ADDR_CLEAR:    data <= data & ~wd;
        ADDR_TOGGLE:   data <= data ^ wd;
        ADDR_BLINK_EN: mask <= wd;
        ADDR_PERIOD:   period <= pw;
        default: ;
      endcase
    end
  // The timer sees the incoming value during a PERIOD write so the reload uses it.
  led_blink_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
    .clk(clk), .reset_n(reset_n), .period(load ? pw : period), .load(load), .phase(phase)
  );
  assign out_port = data ^ (mask & {WIDTH{phase}});
  always_comb begin
    status = '0;
    status[STATUS_PHASE] = phase;
    status[STATUS_EN] = period != '0;
    readdata = !chipselect ? 32'd0 :
               address == ADDR_DATA     ? 32'(data) :
               address == ADDR_BLINK_EN ? 32'(mask) :
               address == ADDR_PERIOD   ? 32'(period) :
               address == ADDR_STATUS   ? status : 32'd0;
  end
endmodule

// File: doc/led_pio_blink.md
LED_PIO_BLINK -- requirements
Module: led_pio_blink

Interface
REQ-001 Parameter WIDTH, 4, number of LED output bits (legal 1..32).
REQ-002 Parameter PRESCALE_W, 24, width of the blink period register/counter (legal 1..32).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  3  register select.
REQ-006 chipselect  input  1  slave select, active high.
REQ-007 write_n  input  1  write strobe, active low; write = chipselect & ~write_n.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data, combinational from address, zero wait state.
REQ-010 out_port  output  WIDTH  LED drive.

Function
REQ-011 Register map SHALL be: 0 DATA (rw), 1 SET (wo), 2 CLEAR (wo), 3 TOGGLE (wo), 4 BLINK_EN (rw), 5 PERIOD (rw), 6 STATUS (ro), 7 reserved.
REQ-012 Write DATA: DATA <= writedata[WIDTH-1:0] on the write edge.
REQ-013 Write SET/CLEAR/TOGGLE: DATA <= DATA | wd, DATA & ~wd, DATA ^ wd respectively (wd = writedata[WIDTH-1:0]); result visible the next cycle.
REQ-014 Write BLINK_EN: mask <= writedata[WIDTH-1:0].
REQ-015 Write PERIOD: period <= writedata[PRESCALE_W-1:0]; counter <= same value; phase <= 0, all in the same cycle.
REQ-016 Blink timer: if period != 0, counter decrements each cycle; when counter == 0, counter <= period and phase toggles; phase thus toggles every period+1 cycles.
REQ-017 period == 0: counter held 0, phase held 0 (blink disabled).
REQ-018 A PERIOD write takes precedence over the timer reload/toggle in the same cycle.
REQ-019 out_port SHALL equal DATA ^ (mask & {WIDTH{phase}}), registered-state only (no combinational path from bus inputs).
REQ-020 Reads: DATA and BLINK_EN return value zero-extended to 32; PERIOD returns period zero-extended; STATUS returns {30'b0, period!=0, phase}; SET, CLEAR, TOGGLE, reserved return 0.
REQ-021 readdata SHALL be 0 whenever chipselect is 0.
REQ-022 Writes to STATUS or reserved address SHALL have no effect.
REQ-023 Writedata bits above WIDTH (or PRESCALE_W for PERIOD) SHALL be ignored.

Reset
REQ-024 On reset_n low, asynchronously: DATA = 0, mask = 0, period = 0, counter = 0, phase = 0; hence out_port = 0 and readdata depends only on address/chipselect.
REQ-025 Reset asserted mid-blink SHALL abort the cycle; after release blinking stays disabled until PERIOD is rewritten.

Structure
REQ-026 Shared package led_pio_pkg SHALL hold register address constants (ADDR_DATA ... ADDR_STATUS) and STATUS bit positions.
REQ-027 Blink counter/phase logic SHALL be a sub-module led_blink_timer (inputs period, load; output phase), parametrised by PRESCALE_W.
REQ-028 Target size 120-400 lines of RTL total.

Verification
REQ-029 Reset, then read addresses 0-7 -> all return 0; out_port = 0.
REQ-030 Write DATA=0xA, SET=0x1, CLEAR=0x8, TOGGLE=0x6 -> out_port sequence 0xA, 0xB, 0x3, 0x5, each one cycle after its write; DATA read = 0x5.
REQ-031 DATA=0x0, BLINK_EN=0x3, PERIOD=2 -> out_port alternates 0x0/0x3 every 3 cycles; STATUS reads 0x2/0x3 in step with phase.
REQ-032 While blinking (phase=1), write PERIOD=0 -> next cycle phase=0, out_port = DATA, STATUS = 0; counter stays 0.
REQ-033 Write DATA=0xFFFFFFFF with WIDTH=4 -> DATA reads 0x0000000F; write STATUS=0xFFFFFFFF -> no state change.
REQ-034 Assert reset_n mid-blink (PERIOD=5, phase=1) asynchronously between clock edges -> out_port = 0 immediately; after release out_port stays 0 for 20 cycles.
